serial_limb_multiplier: RTL and testbench
=========================================

SERIAL_LIMB_MULTIPLIER -- requirements
Module: serial_limb_multiplier

Interface
REQ-001 SHALL have parameter LIMB_BITS, default 17, meaning the width of one operand limb and of each DSP multiplier input.
REQ-002 SHALL have parameter NUM_LIMBS, default 4, meaning the number of limbs per operand (legal range 2..16).
REQ-003 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit; operands a/b are valid.
REQ-006 SHALL have port in_ready, output, 1 bit; the block can accept operands.
REQ-007 SHALL have port a, input, NUM_LIMBS*LIMB_BITS bits; unsigned multiplicand.
REQ-008 SHALL have port b, input, NUM_LIMBS*LIMB_BITS bits; unsigned multiplier operand.
REQ-009 SHALL have port out_valid, output, 1 bit; p holds a finished product.
REQ-010 SHALL have port out_ready, input, 1 bit; the consumer accepts p.
REQ-011 SHALL have port p, output, 2*NUM_LIMBS*LIMB_BITS bits; the full unsigned product a*b.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, MUL, DRAIN, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; an input transfer occurs on an edge where in_valid&&in_ready.
REQ-014 SHALL, on an input transfer, register a and b, clear the accumulator, set limb indices i=j=0, and enter MUL.
REQ-015 SHALL, in MUL, present a limb i and b limb j to one registered LIMB_BITS x LIMB_BITS multiplier each cycle, with j innermost; i and j wrap 0..NUM_LIMBS-1.
REQ-016 SHALL issue exactly NUM_LIMBS^2 pairs, then enter DRAIN on the edge that registers the last pair.
REQ-017 SHALL track multiplier latency (1 cycle) with a 1-bit valid pipe and shift amount pipe, and add each registered product to the accumulator shifted left by (i+j)*LIMB_BITS one cycle after issue.
REQ-018 SHALL size the accumulator at 2*NUM_LIMBS*LIMB_BITS bits; the true product never overflows it and no carry is discarded.
REQ-019 SHALL perform the final accumulation in DRAIN and enter DONE on the next edge.
REQ-020 SHALL have a latency of NUM_LIMBS^2+1 cycles from the input-transfer edge to the edge that raises out_valid (17 cycles at default).
REQ-021 SHALL drive out_valid=1 only in DONE, with p equal to the accumulator.
REQ-022 SHALL hold p and out_valid stable while out_valid&&!out_ready.
REQ-023 SHALL return to IDLE on out_valid&&out_ready; in_ready rises on that same edge, and there is no overlap of jobs.
REQ-024 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-025 SHALL allow a/b to change after the transfer edge without affecting the product.

Reset
REQ-026 SHALL, on rst_n=0, force state=IDLE, in_ready=1, out_valid=0, p/accumulator=0, indices=0, and valid pipe=0, regardless of clock.
REQ-027 SHALL abandon an in-flight job on reset mid-MUL/DRAIN/DONE, producing no out_valid after release until a new input transfer.
REQ-028 SHALL register the multiplier product output without reset; a stale product SHALL never be accumulated because the valid pipe is cleared.

Structure
REQ-029 SHALL place LIMB_BITS/NUM_LIMBS defaults and the FSM state enum typedef in shared package mul_pkg.
REQ-030 SHALL instantiate the team's existing registered multiplier primitive once as the sole sub-module, with A_BIT_LEN=B_BIT_LEN=LIMB_BITS.
REQ-031 SHALL contain the accumulator, shifter, FSM, and handshake logic in this module.

Verification
REQ-032 SHALL pass this directed scenario: a=3, b=5, out_ready=1 -> out_valid 17 cycles after transfer, with p=15.
REQ-033 SHALL pass this directed scenario: a=b=2^68-1 -> p=2^136-2^69+1, which exercises full carry propagation.
REQ-034 SHALL pass this directed scenario: a=2^17, b=2^51 -> p=2^68, which checks cross-limb shift placement.
REQ-035 SHALL pass this directed scenario: out_ready=0 for 10 cycles after out_valid -> p stable, in_ready=0, and in_valid pulses ignored; then on out_ready=1 a single transfer occurs and in_ready=1 the next cycle.
REQ-036 SHALL pass this directed scenario: rst_n low for 1 cycle at issue 8 of a=b=2^68-1 -> out_valid=0, in_ready=1; then a=7, b=6 -> p=42.
REQ-037 SHALL pass this directed scenario: two back-to-back jobs (a=0,b=x then a=1,b=2^68-1) with in_valid held high -> p=0 then p=2^68-1, with no accumulator carry-over.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared defaults and FSM state type for the serial limb multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int LIMB_BITS_DEF = 17;
    localparam int NUM_LIMBS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_reg.sv
`default_nettype none
// ============================================================================
// Module      : mul_reg
// Description : Unsigned multiplier with a registered, non-reset product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_reg #(
    parameter int A_BIT_LEN = 17,
    parameter int B_BIT_LEN = 17
) (
    input  logic                           clk,
    input  logic [A_BIT_LEN-1:0]           a_i,
    input  logic [B_BIT_LEN-1:0]           b_i,
    output logic [A_BIT_LEN+B_BIT_LEN-1:0] p_o
);

    localparam int PW = A_BIT_LEN + B_BIT_LEN;

    logic [PW-1:0] p_q;

    always_ff @(posedge clk) begin
        p_q <= PW'(a_i) * PW'(b_i);
    end

    assign p_o = p_q;

endmodule
`default_nettype wire

// File: rtl/serial_limb_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : serial_limb_multiplier
// Description : Full-width unsigned multiply built from one limb multiplier,
//               issuing NUM_LIMBS^2 limb pairs and accumulating shifted partials.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_limb_multiplier
    import mul_pkg::*;
#(
    parameter int LIMB_BITS = LIMB_BITS_DEF,
    parameter int NUM_LIMBS = NUM_LIMBS_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_LIMBS*LIMB_BITS-1:0]     a,
    input  logic [NUM_LIMBS*LIMB_BITS-1:0]     b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [2*NUM_LIMBS*LIMB_BITS-1:0]   p
);

    localparam int W  = NUM_LIMBS * LIMB_BITS;
    localparam int PW = 2 * W;
    localparam int IW = $clog2(NUM_LIMBS);
    localparam int SW = $clog2(2 * NUM_LIMBS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LIMBS - 1);

    state_t                 state_q;
    logic [W-1:0]           a_q, b_q;
    logic [PW-1:0]          acc_q;
    logic [IW-1:0]          i_q, j_q;
    logic                   vld_q;
    logic [SW-1:0]          sh_q;
    logic                   in_ready_q, out_valid_q;

    logic [LIMB_BITS-1:0]   a_limb, b_limb;
    logic [2*LIMB_BITS-1:0] prod;
    logic [PW-1:0]          addend;
    logic [SW-1:0]          sh_d;

    always_comb begin
        a_limb = a_q[i_q*LIMB_BITS +: LIMB_BITS];
        b_limb = b_q[j_q*LIMB_BITS +: LIMB_BITS];
        sh_d   = SW'(i_q) + SW'(j_q);
        addend = PW'(prod) << (32'(sh_q) * LIMB_BITS);
    end

    mul_reg #(
        .A_BIT_LEN (LIMB_BITS),
        .B_BIT_LEN (LIMB_BITS)
    ) u_mul (
        .clk (clk),
        .a_i (a_limb),
        .b_i (b_limb),
        .p_o (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            vld_q       <= 1'b0;
            sh_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // Product issued last cycle lands in the accumulator this edge.
            vld_q <= (state_q == MUL);
            sh_q  <= sh_d;
            if (vld_q) begin
                acc_q <= acc_q + addend;
            end

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    if (j_q == LAST_IDX) begin
                        j_q <= '0;
                        if (i_q == LAST_IDX) begin
                            i_q     <= '0;
                            state_q <= DRAIN;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DRAIN: begin
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p         = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_limb_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_limb_multiplier
// Description : Randomized and directed self-checking bench for the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_limb_multiplier;

    localparam int LB = 17;
    localparam int NL = 4;
    localparam int W  = LB * NL;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] p;

    int checks   = 0;
    int failures = 0;

    serial_limb_multiplier #(
        .LIMB_BITS (LB),
        .NUM_LIMBS (NL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        v = W'({$urandom, $urandom, $urandom});
        case ($urandom_range(0, 3))
            0: rnd = v;
            1: rnd = '1;
            2: rnd = W'(v[LB-1:0]) << (LB * $urandom_range(0, NL - 1));
            default: rnd = W'(v[7:0]);
        endcase
    endfunction

    // One full job: transfer, wait for result, optional consumer stall, ack.
    task automatic do_job(input logic [W-1:0] aa, input logic [W-1:0] bb, input int stall);
        logic [PW-1:0] exp;
        logic [PW-1:0] held;
        int n;
        exp = PW'(aa) * PW'(bb);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", PW'(in_ready), PW'(1));
        a = aa; b = bb; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_busy", PW'(in_ready), PW'(0));
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rnd(); b = rnd();
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        check("latency", PW'(n), PW'(17));
        check("product", p, exp);
        held = p;
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rnd(); b = rnd();
            @(posedge clk); #1;
            check("hold_p", p, held);
            check("hold_valid", PW'(out_valid), PW'(1));
            check("hold_in_ready", PW'(in_ready), PW'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ack_in_ready", PW'(in_ready), PW'(1));
        check("ack_out_valid", PW'(out_valid), PW'(0));
    endtask

    initial begin
        int highs;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", PW'(in_ready), PW'(1));
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_p", p, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_job(W'(3), W'(5), 0);
        do_job('1, '1, 0);
        do_job(W'(1) << 17, W'(1) << 51, 0);
        do_job(rnd(), rnd(), 10);

        // Reset in the middle of a job.
        a = '1; b = '1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", PW'(out_valid), PW'(0));
        check("midrst_in_ready", PW'(in_ready), PW'(1));
        check("midrst_p", p, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        highs = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid) highs++;
        end
        check("postrst_no_valid", PW'(highs), PW'(0));
        do_job(W'(7), W'(6), 0);

        do_job('0, rnd(), 0);
        do_job(W'(1), '1, 0);

        for (int t = 0; t < 20; t++) begin
            do_job(rnd(), rnd(), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
